// File: rtl/hwpe_ctrl_pkg.sv
// Shared types and constants for the HWPE control-port responder.
package hwpe_ctrl_pkg;

  localparam int unsigned NrCores       = 9;
  localparam int unsigned NumArgs       = 16;
  localparam int unsigned JobQueueDepth = 2;
  localparam int unsigned JobIdWidth    = 8;
  localparam int unsigned UserWidth     = 8;
  localparam int unsigned CntWidth      = $clog2(JobQueueDepth + 1);

  // Word offsets (addr[7:2])
  localparam logic [5:0] REG_ACQUIRE    = 6'h00;
  localparam logic [5:0] REG_TRIGGER    = 6'h01;
  localparam logic [5:0] REG_STATUS     = 6'h02;
  localparam logic [5:0] REG_LAST_DONE  = 6'h03;
  localparam logic [5:0] REG_SOFT_CLEAR = 6'h04;
  // ARG[0..15] occupy offsets 0x10..0x1F, i.e. offset[5:4] == 2'b01
  localparam logic [1:0] REG_ARG_PAGE   = 2'b01;

  // STATUS field positions
  localparam int unsigned STATUS_LOCKED_BIT  = 0;
  localparam int unsigned STATUS_RUNNING_BIT = 1;
  localparam int unsigned STATUS_QUEUED_LSB  = 4;
  localparam int unsigned STATUS_NEXT_ID_LSB = 8;
  localparam int unsigned STATUS_OWNER_LSB   = 16;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 write;
    logic [31:0]          data;
    logic [3:0]           strb;
    logic [UserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  typedef struct packed {
    logic [NumArgs*32-1:0]  args;
    logic [JobIdWidth-1:0]  id;
    logic [UserWidth-1:0]   owner;
  } job_t;

  typedef struct packed {
    logic [JobIdWidth-1:0]  id;
    logic [UserWidth-1:0]   owner;
  } run_t;

  // Replace the bytes of old_w selected by strb with those of new_w
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hwpe_job_fifo.sv
// Small register-based synchronous FIFO with clear and occupancy count.
module hwpe_job_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  // A push into a full FIFO is allowed when the head leaves in the same cycle
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; clear behaves like reset
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage; contents are don't-care until marked valid by the count
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwpe_ctrl_responder.sv
// Job-offload register file behind the HWPE TCDM control port.
module hwpe_ctrl_responder
  import hwpe_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  tcdm_req_t             req_i,
  output tcdm_rsp_t             rsp_o,
  output logic                  job_valid_o,
  input  logic                  job_ready_i,
  output logic [NumArgs*32-1:0] job_args_o,
  output logic [JobIdWidth-1:0] job_id_o,
  input  logic                  done_i,
  output logic                  clear_o,
  output logic [NrCores-1:0]    evt_o
);

  lock_state_e            state_q;
  logic [UserWidth-1:0]   owner_q;
  logic [JobIdWidth-1:0]  next_id_q, last_done_q;
  logic [31:0]            args_q [NumArgs];
  logic                   rsp_valid_q, clear_q;
  logic [31:0]            rsp_data_q;
  logic [NrCores-1:0]     evt_q, evt_d;

  logic [NumArgs*32-1:0]  args_flat;
  logic [5:0]             off;
  logic                   rd_req, wr_req, is_owner, arg_hit;
  logic                   acq_ok, trig, sclr, arg_wr;
  logic [CntWidth:0]      occupancy;
  logic [31:0]            rdata;
  logic                   unused_addr_bits;

  job_t                   job_push_data, job_head;
  logic                   job_valid, job_pop;
  logic [CntWidth-1:0]    job_cnt, run_cnt;
  run_t                   run_head;
  logic                   run_valid, run_pop;

  for (genvar gi = 0; gi < NumArgs; gi++) begin : g_args
    assign args_flat[gi*32 +: 32] = args_q[gi];
  end

  assign off              = req_i.q.addr[7:2];
  assign unused_addr_bits = ^{req_i.q.addr[31:8], req_i.q.addr[1:0]};
  assign rd_req    = req_i.q_valid && !req_i.q.write;
  assign wr_req    = req_i.q_valid &&  req_i.q.write;
  assign is_owner  = (state_q == LOCK_HELD) && (req_i.q.user == owner_q);
  assign arg_hit   = (off[5:4] == REG_ARG_PAGE);
  assign occupancy = {1'b0, job_cnt} + {1'b0, run_cnt};
  assign acq_ok    = rd_req && (off == REG_ACQUIRE) && (state_q == LOCK_IDLE)
                     && (occupancy < (CntWidth+1)'(JobQueueDepth));
  assign trig      = wr_req && (off == REG_TRIGGER) && is_owner;
  assign sclr      = wr_req && (off == REG_SOFT_CLEAR);
  assign arg_wr    = wr_req && arg_hit && is_owner;

  assign job_push_data = '{args: args_flat, id: next_id_q, owner: owner_q};
  assign job_pop       = job_valid && job_ready_i;
  // Soft clear flushes the running job, so its done gets no event
  assign run_pop       = done_i && run_valid && !sclr;

  hwpe_job_fifo #(.Width($bits(job_t)), .Depth(JobQueueDepth)) i_job_queue (
    .clk_i, .rst_i, .clr_i(sclr),
    .push_i(trig), .data_i(job_push_data), .pop_i(job_pop),
    .data_o(job_head), .valid_o(job_valid), .count_o(job_cnt)
  );

  hwpe_job_fifo #(.Width($bits(run_t)), .Depth(JobQueueDepth)) i_run_fifo (
    .clk_i, .rst_i, .clr_i(sclr),
    .push_i(job_pop), .data_i({job_head.id, job_head.owner}), .pop_i(run_pop),
    .data_o(run_head), .valid_o(run_valid), .count_o(run_cnt)
  );

  // Read mux, evaluated against pre-update state
  always_comb begin
    rdata = '0;
    case (off)
      REG_ACQUIRE:   rdata = acq_ok ? 32'(next_id_q) : 32'hFFFF_FFFF;
      REG_STATUS: begin
        rdata[STATUS_LOCKED_BIT]          = (state_q == LOCK_HELD);
        rdata[STATUS_RUNNING_BIT]         = run_valid;
        rdata[STATUS_QUEUED_LSB +: 4]     = 4'(job_cnt);
        rdata[STATUS_NEXT_ID_LSB +: 8]    = 8'(next_id_q);
        rdata[STATUS_OWNER_LSB +: 8]      = 8'(owner_q);
      end
      REG_LAST_DONE: rdata = 32'(last_done_q);
      default:       if (arg_hit) rdata = args_q[off[3:0]];
    endcase
  end

  // One-hot completion event for the owner of the retiring job
  always_comb begin
    evt_d = '0;
    if (run_pop) begin
      for (int c = 0; c < NrCores; c++) evt_d[c] = (run_head.owner == UserWidth'(c));
    end
  end

  // Lock FSM, register file and registered response/event outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= LOCK_IDLE;
      owner_q     <= '0;
      next_id_q   <= '0;
      last_done_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      clear_q     <= 1'b0;
      evt_q       <= '0;
      for (int a = 0; a < NumArgs; a++) args_q[a] <= '0;
    end else begin
      rsp_valid_q <= req_i.q_valid;
      rsp_data_q  <= rd_req ? rdata : '0;
      clear_q     <= sclr;
      evt_q       <= evt_d;
      if (run_pop) last_done_q <= run_head.id;
      if (arg_wr) args_q[off[3:0]] <= byte_merge(args_q[off[3:0]], req_i.q.data, req_i.q.strb);
      if (sclr) begin
        state_q <= LOCK_IDLE;
        owner_q <= '0;
      end else if (acq_ok) begin
        state_q <= LOCK_HELD;
        owner_q <= req_i.q.user;
      end else if (trig) begin
        state_q   <= LOCK_IDLE;
        owner_q   <= '0;
        next_id_q <= next_id_q + 1'b1;
      end
    end
  end

  // A completion with nothing running indicates an engine protocol error
  assert property (@(posedge clk_i) disable iff (rst_i) done_i |-> run_valid);

  always_comb begin
    rsp_o          = '0;
    rsp_o.q_ready  = 1'b1;
    rsp_o.p_valid  = rsp_valid_q;
    rsp_o.p.data   = rsp_data_q;
  end

  assign job_valid_o = job_valid;
  assign job_args_o  = job_valid ? job_head.args : '0;
  assign job_id_o    = job_valid ? job_head.id : '0;
  assign clear_o     = clear_q;
  assign evt_o       = evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_responder.sv
// Directed self-checking bench for hwpe_ctrl_responder.
module tb_hwpe_ctrl_responder;
  import hwpe_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  tcdm_req_t             req;
  tcdm_rsp_t             rsp;
  logic                  job_valid, job_ready, done, clear;
  logic [NumArgs*32-1:0] job_args;
  logic [JobIdWidth-1:0] job_id;
  logic [NrCores-1:0]    evt;

  int   n_cmp = 0;
  int   n_err = 0;
  logic last_pv;
  logic [31:0] rd;

  always #5 clk = ~clk;

  hwpe_ctrl_responder dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .rsp_o(rsp),
    .job_valid_o(job_valid), .job_ready_i(job_ready), .job_args_o(job_args),
    .job_id_o(job_id), .done_i(done), .clear_o(clear), .evt_o(evt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request, driven at a falling edge; returns at the falling edge where the response is valid
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [7:0] user, output logic [31:0] rdata);
    req.q_valid = 1'b1;
    req.q.addr  = addr;
    req.q.write = wr;
    req.q.data  = wdata;
    req.q.strb  = strb;
    req.q.user  = user;
    @(negedge clk);
    req     = '0;
    rdata   = rsp.p.data;
    last_pv = rsp.p_valid;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [7:0] user,
                        input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b0, addr, 32'h0, 4'h0, user, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [7:0] user);
    logic [31:0] d;
    xfer(1'b1, addr, data, strb, user, d);
  endtask

  task automatic handshake(input string tag, input logic [7:0] exp_id);
    check({tag, "_valid"}, job_valid, 1);
    check({tag, "_id"}, job_id, exp_id);
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
  endtask

  task automatic done_pulse(input string tag, input logic [NrCores-1:0] exp_evt);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check(tag, evt, exp_evt);
  endtask

  task automatic run_one_job(input int core, input logic [7:0] exp_id);
    rd_chk("wrap_acq", 32'h00, 8'(core), {24'h0, exp_id});
    wr(32'h04, 32'h0, 4'hF, 8'(core));
    handshake("wrap_job", exp_id);
    done_pulse("wrap_evt", NrCores'(1) << core);
  endtask

  initial begin
    rst_i = 1'b1;
    req = '0;
    job_ready = 1'b0;
    done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p_valid", rsp.p_valid, 0);
    check("rst_p_data", rsp.p.data, 0);
    check("rst_job_valid", job_valid, 0);
    check("rst_job_id", job_id, 0);
    check("rst_evt", evt, 0);
    check("rst_clear", clear, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // Acquire by core 3, contention from core 5
    rd_chk("acq_core3", 32'h00, 8'd3, 32'h0000_0000);
    check("acq_p_valid", last_pv, 1);
    @(negedge clk);
    check("p_valid_one_cycle", rsp.p_valid, 0);
    rd_chk("status_locked", 32'h08, 8'd3, 32'h0003_0001);
    rd_chk("acq_core5_busy", 32'h00, 8'd5, 32'hFFFF_FFFF);
    rd_chk("undef_offset", 32'h20, 8'd3, 32'h0);

    // ARG write with byte mask, then rejected writes/trigger from a non-owner
    xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 8'd3, rd);
    check("write_rsp_data", rd, 0);
    check("write_p_valid", last_pv, 1);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF, 8'd5);
    rd_chk("arg0_masked", 32'h40, 8'd3, 32'h0000_BEEF);
    wr(32'h04, 32'h0, 4'hF, 8'd5);
    check("nonowner_trig", job_valid, 0);

    // Trigger by owner; job visible next cycle
    wr(32'h04, 32'h0, 4'hF, 8'd3);
    check("trig_args", job_args[15:0], 16'hBEEF);
    handshake("job0", 8'd0);
    check("handshake_drains", job_valid, 0);
    done_pulse("evt_core3", 9'b000001000);
    @(negedge clk);
    check("evt_one_cycle", evt, 0);
    rd_chk("last_done0", 32'h0C, 8'd3, 32'h0);
    rd_chk("status_idle", 32'h08, 8'd3, 32'h0000_0100);

    // Fill the queue while the engine stalls
    rd_chk("fill_acq1", 32'h00, 8'd1, 32'h1);
    wr(32'h04, 32'h0, 4'hF, 8'd1);
    rd_chk("fill_acq2", 32'h00, 8'd1, 32'h2);
    wr(32'h04, 32'h0, 4'hF, 8'd1);
    rd_chk("full_acq", 32'h00, 8'd2, 32'hFFFF_FFFF);
    rd_chk("status_full", 32'h08, 8'd2, 32'h0000_0320);
    handshake("fill_job1", 8'd1);
    rd_chk("still_full_acq", 32'h00, 8'd2, 32'hFFFF_FFFF);
    done_pulse("evt_core1", 9'b000000010);
    rd_chk("last_done1", 32'h0C, 8'd2, 32'h1);
    rd_chk("reacq", 32'h00, 8'd2, 32'h3);
    wr(32'h04, 32'h0, 4'hF, 8'd2);
    handshake("drain_job2", 8'd2);
    done_pulse("drain_evt2", 9'b000000010);
    handshake("drain_job3", 8'd3);
    done_pulse("drain_evt3", 9'b000000100);

    // 256 jobs: IDs wrap from 255 back through 0
    for (int i = 0; i < 256; i++) run_one_job(i % 9, 8'((4 + i) % 256));
    rd_chk("wrap_last_done", 32'h0C, 8'd0, 32'h3);

    // Two running jobs, then soft clear together with done
    rd_chk("sc_acq6", 32'h00, 8'd6, 32'h4);
    wr(32'h04, 32'h0, 4'hF, 8'd6);
    handshake("sc_job4", 8'd4);
    rd_chk("sc_acq7", 32'h00, 8'd7, 32'h5);
    wr(32'h04, 32'h0, 4'hF, 8'd7);
    handshake("sc_job5", 8'd5);
    rd_chk("sc_status_run", 32'h08, 8'd0, 32'h0000_0602);
    done = 1'b1;
    wr(32'h10, 32'h1, 4'hF, 8'd0);
    done = 1'b0;
    check("sc_clear_pulse", clear, 1);
    check("sc_no_evt", evt, 0);
    @(negedge clk);
    check("sc_clear_one_cycle", clear, 0);
    check("sc_no_evt_late", evt, 0);
    rd_chk("sc_status", 32'h08, 8'd0, 32'h0000_0600);
    rd_chk("sc_last_done", 32'h0C, 8'd0, 32'h3);
    rd_chk("sc_arg0_kept", 32'h40, 8'd0, 32'h0000_BEEF);

    // Reset while locked with a job queued
    rd_chk("pre_rst_acq", 32'h00, 8'd4, 32'h6);
    wr(32'h44, 32'h1234_5678, 4'hF, 8'd4);
    wr(32'h04, 32'h0, 4'hF, 8'd4);
    check("pre_rst_valid", job_valid, 1);
    check("pre_rst_arg1", job_args[63:32], 32'h1234_5678);
    rd_chk("pre_rst_lock", 32'h00, 8'd8, 32'h7);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_job_valid", job_valid, 0);
    check("mid_rst_job_id", job_id, 0);
    check("mid_rst_args_zero", (job_args == '0), 1);
    check("mid_rst_p_valid", rsp.p_valid, 0);
    check("mid_rst_p_data", rsp.p.data, 0);
    check("mid_rst_evt", evt, 0);
    check("mid_rst_clear", clear, 0);
    rst_i = 1'b0;
    rd_chk("post_rst_acq", 32'h00, 8'd2, 32'h0);
    rd_chk("post_rst_arg1", 32'h44, 8'd2, 32'h0);
    rd_chk("post_rst_status", 32'h08, 8'd2, 32'h0002_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
